// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_alu
// Description : ALU execution unit behind a bgn/rdy level handshake. Most
//               operations finish in one cycle. MUL runs as an iterative
//               shift-add engine and DIV/MOD as a restoring divider, retiring
//               MD_STEP bits per cycle.
// Config      : `define ALU_MULDIV_EN to build the MUL/DIV/MOD engines; when
//               undefined, those opcodes behave as unknown opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_alu #(
    parameter int DATA_W  = 16,
    parameter int MD_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bgn,
    input  logic [5:0]        opcode,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] acc1,
    output logic [DATA_W-1:0] acc2,
    output logic              zero,
    output logic              negative,
    output logic              carry,
    output logic              overflow,
    output logic              rdy
);

    localparam int c_ITER  = DATA_W / MD_STEP;
    localparam int c_CNT_W = (c_ITER > 1) ? $clog2(c_ITER) : 1;
    localparam int c_MSB   = DATA_W - 1;

    localparam logic [4:0] c_OP_ADD = 5'h01;
    localparam logic [4:0] c_OP_SUB = 5'h02;
    localparam logic [4:0] c_OP_LSR = 5'h03;
    localparam logic [4:0] c_OP_LSL = 5'h04;
    localparam logic [4:0] c_OP_RSR = 5'h05;
    localparam logic [4:0] c_OP_RSL = 5'h06;
    localparam logic [4:0] c_OP_MUL = 5'h07;
    localparam logic [4:0] c_OP_DIV = 5'h08;
    localparam logic [4:0] c_OP_MOD = 5'h09;
    localparam logic [4:0] c_OP_AND = 5'h0A;
    localparam logic [4:0] c_OP_OR  = 5'h0B;
    localparam logic [4:0] c_OP_XOR = 5'h0C;
    localparam logic [4:0] c_OP_NOT = 5'h0D;
    localparam logic [4:0] c_OP_CMP = 5'h0E;
    localparam logic [4:0] c_OP_TST = 5'h0F;
    localparam logic [4:0] c_OP_INC = 5'h10;
    localparam logic [4:0] c_OP_DEC = 5'h11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [4:0]          w_op;
    logic                w_unused;
    logic [DATA_W-1:0]   w_res;
    logic [DATA_W-1:0]   w_res2;
    logic                w_c;
    logic                w_v;
    logic                w_wr_acc1;
    logic                w_wr_acc2;
    logic                w_wr_flags;
    logic                w_is_iter;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_dif;
    logic [DATA_W:0]     w_inc;
    logic [DATA_W:0]     w_dec;
    logic [4:0]          w_shamt;
    logic [3:0]          w_rotamt;
    logic [DATA_W-1:0]   w_lsr_res;
    logic                w_lsr_c;
    logic [DATA_W-1:0]   w_lsl_res;
    logic                w_lsl_c;
    logic [DATA_W-1:0]   w_rsr;
    logic [DATA_W-1:0]   w_rsl;

    // The imm flag is resolved upstream; B already carries the right operand.
    assign w_op     = opcode[5:1];
    assign w_unused = opcode[0] | (c_ITER == 0);

    assign w_sum    = {1'b0, A} + {1'b0, B};
    assign w_dif    = {1'b0, A} - {1'b0, B};
    assign w_inc    = {1'b0, A} + {{DATA_W{1'b0}}, 1'b1};
    assign w_dec    = {1'b0, A} - {{DATA_W{1'b0}}, 1'b1};
    assign w_shamt  = B[4:0];
    assign w_rotamt = B[3:0];

    // A guard bit on the shifted-out side captures the last bit lost; it stays 0 for amount 0.
    assign {w_lsr_res, w_lsr_c} = {A, 1'b0} >> w_shamt;
    assign {w_lsl_c, w_lsl_res} = {1'b0, A} << w_shamt;
    assign w_rsr = (A >> w_rotamt) | (A << (DATA_W - int'(w_rotamt)));
    assign w_rsl = (A << w_rotamt) | (A >> (DATA_W - int'(w_rotamt)));

    // Single-cycle result, flag values and write enables for the op presented in IDLE
    always_comb begin
        w_res      = '0;
        w_res2     = '0;
        w_c        = 1'b0;
        w_v        = 1'b0;
        w_wr_acc1  = 1'b0;
        w_wr_acc2  = 1'b0;
        w_wr_flags = 1'b0;
        w_is_iter  = 1'b0;
        case (w_op)
            c_OP_ADD: begin
                w_res      = w_sum[c_MSB:0];
                w_c        = w_sum[DATA_W];
                w_v        = (A[c_MSB] == B[c_MSB]) && (w_res[c_MSB] != A[c_MSB]);
                w_wr_acc1  = 1'b1;
                w_wr_flags = 1'b1;
            end
            c_OP_SUB, c_OP_CMP: begin
                w_res      = w_dif[c_MSB:0];
                w_c        = w_dif[DATA_W];
                w_v        = (A[c_MSB] != B[c_MSB]) && (w_res[c_MSB] != A[c_MSB]);
                w_wr_acc1  = (w_op == c_OP_SUB);
                w_wr_flags = 1'b1;
            end
            c_OP_INC: begin
                w_res      = w_inc[c_MSB:0];
                w_c        = w_inc[DATA_W];
                w_v        = !A[c_MSB] && w_res[c_MSB];
                w_wr_acc1  = 1'b1;
                w_wr_flags = 1'b1;
            end
            c_OP_DEC: begin
                w_res      = w_dec[c_MSB:0];
                w_c        = w_dec[DATA_W];
                w_v        = A[c_MSB] && !w_res[c_MSB];
                w_wr_acc1  = 1'b1;
                w_wr_flags = 1'b1;
            end
            c_OP_LSR: begin
                w_res      = w_lsr_res;
                w_c        = w_lsr_c;
                w_wr_acc1  = 1'b1;
                w_wr_flags = 1'b1;
            end
            c_OP_LSL: begin
                w_res      = w_lsl_res;
                w_c        = w_lsl_c;
                w_wr_acc1  = 1'b1;
                w_wr_flags = 1'b1;
            end
            c_OP_RSR: begin
                w_res      = w_rsr;
                w_c        = (w_rotamt != 4'd0) && w_rsr[c_MSB];
                w_wr_acc1  = 1'b1;
                w_wr_flags = 1'b1;
            end
            c_OP_RSL: begin
                w_res      = w_rsl;
                w_c        = (w_rotamt != 4'd0) && w_rsl[0];
                w_wr_acc1  = 1'b1;
                w_wr_flags = 1'b1;
            end
            c_OP_AND, c_OP_TST: begin
                w_res      = A & B;
                w_wr_acc1  = (w_op == c_OP_AND);
                w_wr_flags = 1'b1;
            end
            c_OP_OR: begin
                w_res      = A | B;
                w_wr_acc1  = 1'b1;
                w_wr_flags = 1'b1;
            end
            c_OP_XOR: begin
                w_res      = A ^ B;
                w_wr_acc1  = 1'b1;
                w_wr_flags = 1'b1;
            end
            c_OP_NOT: begin
                w_res      = ~A;
                w_wr_acc1  = 1'b1;
                w_wr_flags = 1'b1;
            end
`ifdef ALU_MULDIV_EN
            c_OP_MUL: begin
                w_is_iter = 1'b1;
            end
            c_OP_DIV, c_OP_MOD: begin
                // Divide by zero short-circuits the engine and completes immediately.
                if (B == '0) begin
                    w_res      = '1;
                    w_res2     = A;
                    w_v        = 1'b1;
                    w_wr_acc1  = 1'b1;
                    w_wr_acc2  = 1'b1;
                    w_wr_flags = 1'b1;
                end else begin
                    w_is_iter  = 1'b1;
                end
            end
`endif
            default: begin
            end
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic [4:0]          r_op;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0]   w_hi;
    logic [DATA_W-1:0]   w_lo;
    logic [DATA_W:0]     w_madd;
    logic [DATA_W:0]     w_rem;
    logic                w_last;

    assign w_last = (r_cnt == c_CNT_W'(c_ITER - 1));

    // MD_STEP iterations of shift-add multiply ({hi,lo} starts as {0,A}) or restoring divide
    always_comb begin
        w_hi   = r_hi;
        w_lo   = r_lo;
        w_madd = '0;
        w_rem  = '0;
        for (int i = 0; i < MD_STEP; i++) begin
            if (r_op == c_OP_MUL) begin
                w_madd = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : {(DATA_W + 1){1'b0}});
                w_lo   = {w_madd[0], w_lo[DATA_W-1:1]};
                w_hi   = w_madd[DATA_W:1];
            end else begin
                w_rem  = {w_hi, w_lo[DATA_W-1]};
                w_lo   = {w_lo[DATA_W-2:0], 1'b0};
                if (w_rem >= {1'b0, r_b}) begin
                    w_rem   = w_rem - {1'b0, r_b};
                    w_lo[0] = 1'b1;
                end
                w_hi   = w_rem[DATA_W-1:0];
            end
        end
    end

    // Engine operand latch at start, partial-result update each EXEC cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op  <= '0;
            r_b   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (bgn && w_is_iter) begin
                r_op  <= w_op;
                r_b   <= B;
                r_hi  <= '0;
                r_lo  <= A;
                r_cnt <= '0;
            end
        end else if (r_state == S_EXEC) begin
            r_hi  <= w_hi;
            r_lo  <= w_lo;
            r_cnt <= r_cnt + 1'b1;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; dropping bgn always returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bgn) begin
                    w_state_nxt = w_is_iter ? S_EXEC : S_DONE;
                end
            end
`ifdef ALU_MULDIV_EN
            S_EXEC: begin
                if (!bgn) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (!bgn) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Result and flag registers, written only when an operation completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc1     <= '0;
            acc2     <= '0;
            zero     <= 1'b0;
            negative <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            rdy      <= 1'b0;
        end else begin
            rdy <= (w_state_nxt == S_DONE);
            if ((r_state == S_IDLE) && bgn) begin
                if (w_wr_acc1) begin
                    acc1 <= w_res;
                end
                if (w_wr_acc2) begin
                    acc2 <= w_res2;
                end
                if (w_wr_flags) begin
                    zero     <= (w_res == '0);
                    negative <= w_res[c_MSB];
                    carry    <= w_c;
                    overflow <= w_v;
                end
            end
`ifdef ALU_MULDIV_EN
            if ((r_state == S_EXEC) && bgn && w_last) begin
                acc1     <= w_lo;
                acc2     <= w_hi;
                zero     <= (r_op == c_OP_MUL) ? ({w_hi, w_lo} == '0) : (w_lo == '0);
                negative <= w_lo[c_MSB];
                carry    <= (r_op == c_OP_MUL) && (w_hi != '0);
                overflow <= 1'b0;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_alu
// Description : Self-checking bench for multicycle_alu. A behavioural model
//               built from plain integer arithmetic predicts acc1/acc2, flags
//               and latency. Honours `define ALU_MULDIV_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_alu;

    localparam int DW = 16;

    localparam logic [4:0] OP_ADD = 5'h01;
    localparam logic [4:0] OP_SUB = 5'h02;
    localparam logic [4:0] OP_LSR = 5'h03;
    localparam logic [4:0] OP_LSL = 5'h04;
    localparam logic [4:0] OP_RSR = 5'h05;
    localparam logic [4:0] OP_RSL = 5'h06;
    localparam logic [4:0] OP_MUL = 5'h07;
    localparam logic [4:0] OP_DIV = 5'h08;
    localparam logic [4:0] OP_MOD = 5'h09;
    localparam logic [4:0] OP_AND = 5'h0A;
    localparam logic [4:0] OP_OR  = 5'h0B;
    localparam logic [4:0] OP_XOR = 5'h0C;
    localparam logic [4:0] OP_NOT = 5'h0D;
    localparam logic [4:0] OP_CMP = 5'h0E;
    localparam logic [4:0] OP_TST = 5'h0F;
    localparam logic [4:0] OP_INC = 5'h10;
    localparam logic [4:0] OP_DEC = 5'h11;

    logic        clk = 1'b0;
    logic        rst;
    logic        bgn;
    logic [5:0]  opcode;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] acc1;
    logic [15:0] acc2;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;
    logic        rdy;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_acc1;
    logic [15:0] m_acc2;
    logic        m_z;
    logic        m_n;
    logic        m_c;
    logic        m_v;

    multicycle_alu #(
        .DATA_W  (16),
        .MD_STEP (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bgn      (bgn),
        .opcode   (opcode),
        .A        (A),
        .B        (B),
        .acc1     (acc1),
        .acc2     (acc2),
        .zero     (zero),
        .negative (negative),
        .carry    (carry),
        .overflow (overflow),
        .rdy      (rdy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_acc1 = '0; m_acc2 = '0;
        m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
    endtask

    // Architectural effect of one completed operation
    task automatic model_apply(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        int          sa, sb, wide, s;
        logic [15:0] bb, r;
        logic [31:0] p;
        bit          wf;
        bb = (op == OP_INC || op == OP_DEC) ? 16'd1 : b;
        sa = int'($signed(a));
        sb = int'($signed(bb));
        r  = '0;
        wf = 1'b0;
        case (op)
            OP_ADD, OP_INC: begin
                wide = sa + sb; r = a + bb; m_acc1 = r; wf = 1'b1;
                m_c = (int'(a) + int'(bb)) > 65535;
                m_v = (wide > 32767) || (wide < -32768);
            end
            OP_SUB, OP_DEC, OP_CMP: begin
                wide = sa - sb; r = a - bb; wf = 1'b1;
                if (op != OP_CMP) m_acc1 = r;
                m_c = a < bb;
                m_v = (wide > 32767) || (wide < -32768);
            end
            OP_LSR, OP_LSL: begin
                s = int'(b[4:0]);
                if (s >= 16) r = '0;
                else if (op == OP_LSR) r = a >> s;
                else r = a << s;
                if (s == 0 || s > 16) m_c = 1'b0;
                else if (op == OP_LSR) m_c = a[s-1];
                else m_c = a[16-s];
                m_v = 1'b0; m_acc1 = r; wf = 1'b1;
            end
            OP_RSR, OP_RSL: begin
                s = int'(b[3:0]);
                if (op == OP_RSR) r = (a >> s) | (a << (16 - s));
                else r = (a << s) | (a >> (16 - s));
                if (s == 0) m_c = 1'b0;
                else if (op == OP_RSR) m_c = a[s-1];
                else m_c = a[16-s];
                m_v = 1'b0; m_acc1 = r; wf = 1'b1;
            end
            OP_AND, OP_TST, OP_OR, OP_XOR, OP_NOT: begin
                if (op == OP_OR) r = a | b;
                else if (op == OP_XOR) r = a ^ b;
                else if (op == OP_NOT) r = ~a;
                else r = a & b;
                if (op != OP_TST) m_acc1 = r;
                m_c = 1'b0; m_v = 1'b0; wf = 1'b1;
            end
`ifdef ALU_MULDIV_EN
            OP_MUL: begin
                p = {16'h0, a} * {16'h0, b};
                m_acc1 = p[15:0]; m_acc2 = p[31:16];
                m_z = (p == 0); m_n = p[15];
                m_c = (p[31:16] != 0); m_v = 1'b0;
            end
            OP_DIV, OP_MOD: begin
                if (b == 0) begin
                    m_acc1 = 16'hFFFF; m_acc2 = a; m_v = 1'b1;
                end else begin
                    m_acc1 = a / b; m_acc2 = a % b; m_v = 1'b0;
                end
                m_c = 1'b0; m_z = (m_acc1 == 0); m_n = m_acc1[15];
            end
`endif
            default: begin
            end
        endcase
        if (wf) begin
            m_z = (r == 0);
            m_n = r[15];
        end
    endtask

    function automatic int exp_lat(input logic [4:0] op, input logic [15:0] b);
`ifdef ALU_MULDIV_EN
        if (op == OP_MUL) return DW + 1;
        if ((op == OP_DIV || op == OP_MOD) && b != 0) return DW + 1;
`endif
        return 1;
    endfunction

    // Issue one op from IDLE (called at a negedge), scramble A/B while it runs,
    // report cycles until rdy (-1 on timeout), then release bgn and return to IDLE.
    task automatic do_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int lat);
        opcode = {op, 1'($urandom_range(0, 1))};
        A = a; B = b; bgn = 1'b1; lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            A = 16'($urandom); B = 16'($urandom);
            if (rdy === 1'b1) begin
                lat = i;
                break;
            end
        end
        bgn = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; bgn = 1'b0; opcode = '0; A = '0; B = '0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({acc1, acc2, zero, negative, carry, overflow, rdy} !== 37'h0) begin
            n_errors++;
            $display("FAIL reset_hold got acc1=%h acc2=%h f=%b%b%b%b rdy=%b expected all 0",
                     acc1, acc2, zero, negative, carry, overflow, rdy);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({acc1, acc2, zero, negative, carry, overflow, rdy} !== 37'h0) begin
            n_errors++;
            $display("FAIL reset_release got acc1=%h acc2=%h rdy=%b expected 0", acc1, acc2, rdy);
        end
    endtask

    task automatic test_directed();
        logic [4:0]  ops [9];
        logic [15:0] as  [9];
        logic [15:0] bs  [9];
        int          lat;
        ops = '{OP_ADD, OP_SUB, OP_ADD, OP_CMP, OP_MUL, OP_DIV, OP_DIV, OP_MOD, OP_LSL};
        as  = '{16'h7FFF, 16'h0003, 16'h0101, 16'h0003, 16'h0100, 16'h0064, 16'h1234, 16'h0064, 16'h8001};
        bs  = '{16'h0001, 16'h0005, 16'h0202, 16'h0005, 16'h0100, 16'h0007, 16'h0000, 16'h0007, 16'h0001};
        for (int i = 0; i < 9; i++) begin
            do_op(ops[i], as[i], bs[i], lat);
            model_apply(ops[i], as[i], bs[i]);
            n_checks++;
            if (lat != exp_lat(ops[i], bs[i])) begin
                n_errors++;
                $display("FAIL dir[%0d] latency got %0d expected %0d", i, lat, exp_lat(ops[i], bs[i]));
            end
            n_checks++;
            if ({acc1, acc2, zero, negative, carry, overflow} !== {m_acc1, m_acc2, m_z, m_n, m_c, m_v}) begin
                n_errors++;
                $display("FAIL dir[%0d] op=%h got acc1=%h acc2=%h zncv=%b%b%b%b expected acc1=%h acc2=%h zncv=%b%b%b%b",
                         i, ops[i], acc1, acc2, zero, negative, carry, overflow,
                         m_acc1, m_acc2, m_z, m_n, m_c, m_v);
            end
            if (i == 0) begin
                n_checks++;
                if ({acc1, negative, overflow, carry, zero} !== {16'h8000, 4'b1100}) begin
                    n_errors++;
                    $display("FAIL add_7fff got acc1=%h nvcz=%b%b%b%b expected 8000 1100",
                             acc1, negative, overflow, carry, zero);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            int          pick, lat;
            logic [4:0]  op;
            logic [15:0] a, b;
            logic [35:0] got, exp, msk;
            pick = int'($urandom_range(0, 19));
            op = (pick <= 16) ? 5'(pick + 1) : 5'($urandom_range(18, 31));
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 7))
                0: a = 16'h7FFF;
                1: a = 16'h8000;
                2: a = 16'h0000;
                3: b = 16'h0000;
                4: b = 16'($urandom_range(0, 40));
                default: begin
                end
            endcase
            do_op(op, a, b, lat);
            model_apply(op, a, b);
            n_checks++;
            if (lat != exp_lat(op, b)) begin
                n_errors++;
                $display("FAIL rand[%0d] op=%h latency got %0d expected %0d", i, op, lat, exp_lat(op, b));
            end
            got = {acc1, acc2, zero, negative, carry, overflow};
            exp = {m_acc1, m_acc2, m_z, m_n, m_c, m_v};
            msk = '1;
            if (op == OP_MUL) msk[2] = 1'b0;
            if (op == OP_MOD) msk[3:2] = 2'b00;
            n_checks++;
            if ((got & msk) !== (exp & msk)) begin
                n_errors++;
                $display("FAIL rand[%0d] op=%h a=%h b=%h got %h expected %h (acc1,acc2,zncv)",
                         i, op, a, b, got, exp);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        opcode = {OP_XOR, 1'b0}; A = 16'h5A5A; B = 16'h0FF0; bgn = 1'b1;
        model_apply(OP_XOR, 16'h5A5A, 16'h0FF0);
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rdy === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_checks++;
        if (lat != 1) begin
            n_errors++;
            $display("FAIL hold_latency got %0d expected 1", lat);
        end
        for (int k = 0; k < 5; k++) begin
            A = 16'($urandom); B = 16'($urandom);
            @(negedge clk);
            n_checks++;
            if (rdy !== 1'b1 || acc1 !== m_acc1) begin
                n_errors++;
                $display("FAIL hold[%0d] got rdy=%b acc1=%h expected rdy=1 acc1=%h", k, rdy, acc1, m_acc1);
            end
        end
        bgn = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rdy !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_release got rdy=%b expected 0", rdy);
        end
        do_op(OP_INC, 16'h7FFF, 16'h0000, lat);
        model_apply(OP_INC, 16'h7FFF, 16'h0000);
        n_checks++;
        if (lat != 1 || {acc1, zero, negative, carry, overflow} !== {m_acc1, m_z, m_n, m_c, m_v}) begin
            n_errors++;
            $display("FAIL after_hold got lat=%0d acc1=%h zncv=%b%b%b%b expected lat=1 acc1=%h zncv=%b%b%b%b",
                     lat, acc1, zero, negative, carry, overflow, m_acc1, m_z, m_n, m_c, m_v);
        end
    endtask

`ifdef ALU_MULDIV_EN
    task automatic test_abort();
        int lat;
        int seen;
        opcode = {OP_MUL, 1'b0}; A = 16'h1234; B = 16'h5678; bgn = 1'b1;
        repeat (6) @(negedge clk);
        bgn = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL abort_rdy got %0d cycles with rdy!=0 expected 0", seen);
        end
        n_checks++;
        if ({acc1, acc2, zero, negative, carry, overflow} !== {m_acc1, m_acc2, m_z, m_n, m_c, m_v}) begin
            n_errors++;
            $display("FAIL abort_hold got acc1=%h acc2=%h expected acc1=%h acc2=%h", acc1, acc2, m_acc1, m_acc2);
        end
        do_op(OP_MUL, 16'hFFFF, 16'hFFFF, lat);
        model_apply(OP_MUL, 16'hFFFF, 16'hFFFF);
        n_checks++;
        if (lat != DW + 1 || {acc1, acc2, carry} !== {m_acc1, m_acc2, m_c}) begin
            n_errors++;
            $display("FAIL after_abort got lat=%0d acc1=%h acc2=%h expected lat=%0d acc1=%h acc2=%h",
                     lat, acc1, acc2, DW + 1, m_acc1, m_acc2);
        end
    endtask
`endif

    task automatic test_async_reset();
        int lat;
        do_op(OP_SUB, 16'h0003, 16'h0005, lat);
        model_apply(OP_SUB, 16'h0003, 16'h0005);
        opcode = {OP_MUL, 1'b0}; A = 16'h0100; B = 16'h0100; bgn = 1'b1;
        repeat (8) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({acc1, acc2, zero, negative, carry, overflow, rdy} !== 37'h0) begin
            n_errors++;
            $display("FAIL async_reset got acc1=%h acc2=%h f=%b%b%b%b rdy=%b expected all 0",
                     acc1, acc2, zero, negative, carry, overflow, rdy);
        end
        bgn = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        do_op(OP_ADD, 16'h8000, 16'h8000, lat);
        model_apply(OP_ADD, 16'h8000, 16'h8000);
        n_checks++;
        if (lat != 1 || {acc1, acc2, zero, negative, carry, overflow} !== {m_acc1, m_acc2, m_z, m_n, m_c, m_v}) begin
            n_errors++;
            $display("FAIL after_reset got lat=%0d acc1=%h acc2=%h zncv=%b%b%b%b expected acc1=%h acc2=%h zncv=%b%b%b%b",
                     lat, acc1, acc2, zero, negative, carry, overflow, m_acc1, m_acc2, m_z, m_n, m_c, m_v);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
`ifdef ALU_MULDIV_EN
        test_abort();
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
